alarm_zone_ctrl: RTL and testbench

Parametrised multi-zone successor of the single-loop door/window alarm FSM. Monitors ZONES sensor inputs, each either delayed (entry timer) or instant, with per-zone bypass captured at arm time, keypad arm/disarm codes, a bounded siren period with automatic silence and re-trigger, and a latched record of tripped zones. Sits between the debounced sensor/keypad front end and the siren/indicator drivers.

---
 rtl/alarm_zone_ctrl.sv | 164 ++++++++++++++++
 tb/tb_alarm_zone_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_zone_ctrl.sv
// Multi-zone intrusion alarm controller.
// Entry delay, instant zones, arm-time bypass, bounded siren and trip latch.
//
// Ports:
//   clk, reset_n        rising-edge clock, synchronous active-low reset
//   ENA                 clock enable; all state frozen while low
//   zones               sensor open flags, 1 = open
//   instant_mask        1 = zone alarms with no entry delay
//   bypass              1 = zone ignored; captured on a successful arm
//   keypad/keypad_valid code entry, qualified for one enabled cycle
//   is_armed/is_wait_delay/alarm_siren/is_silenced  state indicators
//   arm_fail            one-cycle pulse after a rejected arm attempt
//   trip_zones          zones tripped since the last arm
//   delay_remaining     entry counter, 0 outside the entry delay
module alarm_zone_ctrl #(
  parameter int          ZONES       = 4,
  parameter int          ENTRY_DELAY = 100,
  parameter int          SIREN_TIME  = 200,
  parameter logic [3:0]  ARM_CODE    = 4'b0011,
  parameter logic [3:0]  DISARM_CODE = 4'b1100,
  localparam int         MAXT = (ENTRY_DELAY > SIREN_TIME) ?
                                ENTRY_DELAY : SIREN_TIME,
  localparam int         CW   = $clog2(MAXT + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ENA,
  input  logic [ZONES-1:0] zones,
  input  logic [ZONES-1:0] instant_mask,
  input  logic [ZONES-1:0] bypass,
  input  logic [3:0]       keypad,
  input  logic             keypad_valid,
  output logic             is_armed,
  output logic             is_wait_delay,
  output logic             alarm_siren,
  output logic             is_silenced,
  output logic             arm_fail,
  output logic [ZONES-1:0] trip_zones,
  output logic [CW-1:0]    delay_remaining
);

  typedef enum logic [2:0] {
    S_DIS,
    S_ARMED,
    S_WAIT,
    S_ALARM,
    S_SIL
  } state_e;

  localparam logic [CW-1:0] ENTRY_LD = CW'(ENTRY_DELAY - 1);
  localparam logic [CW-1:0] SIREN_LD = CW'(SIREN_TIME - 1);

  state_e           state_q, state_d;
  logic [ZONES-1:0] mask_q, mask_d;
  logic [ZONES-1:0] tz_q, tz_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             fail_q, fail_d;

  logic             arm_ev, disarm_ev;
  logic [ZONES-1:0] trip, inst, fresh;

  // ENA gating is done at the register, so events only need the keypad.
  assign arm_ev    = keypad_valid && (keypad == ARM_CODE);
  assign disarm_ev = keypad_valid && (keypad == DISARM_CODE);

  assign trip  = zones & ~mask_q;
  assign inst  = trip & instant_mask;
  // Only zones not already latched may re-trigger a silenced siren.
  assign fresh = trip & ~tz_q;

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    tz_d    = tz_q;
    cnt_d   = cnt_q;
    fail_d  = 1'b0;
    if (state_q != S_DIS) tz_d = tz_q | trip;
    unique case (state_q)
      S_DIS: begin
        if (arm_ev) begin
          if (~|(zones & ~bypass)) begin
            state_d = S_ARMED;
            mask_d  = bypass;
            tz_d    = '0;
            cnt_d   = '0;
          end else begin
            fail_d = 1'b1;
          end
        end
      end
      S_ARMED: begin
        if (disarm_ev) begin
          state_d = S_DIS;
          cnt_d   = '0;
        end else if (|inst) begin
          state_d = S_ALARM;
          cnt_d   = SIREN_LD;
        end else if (|trip) begin
          state_d = S_WAIT;
          cnt_d   = ENTRY_LD;
        end
      end
      S_WAIT: begin
        if (disarm_ev) begin
          state_d = S_DIS;
          cnt_d   = '0;
        end else if (|inst || cnt_q == '0) begin
          state_d = S_ALARM;
          cnt_d   = SIREN_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_ALARM: begin
        if (disarm_ev) begin
          state_d = S_DIS;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = S_SIL;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_SIL: begin
        if (disarm_ev) begin
          state_d = S_DIS;
          cnt_d   = '0;
        end else if (|fresh) begin
          state_d = S_ALARM;
          cnt_d   = SIREN_LD;
        end
      end
      default: begin
        state_d = S_DIS;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_DIS;
      mask_q  <= '0;
      tz_q    <= '0;
      cnt_q   <= '0;
      fail_q  <= 1'b0;
    end else if (ENA) begin
      state_q <= state_d;
      mask_q  <= mask_d;
      tz_q    <= tz_d;
      cnt_q   <= cnt_d;
      fail_q  <= fail_d;
    end
  end

  assign is_armed        = (state_q == S_ARMED);
  assign is_wait_delay   = (state_q == S_WAIT);
  assign alarm_siren     = (state_q == S_ALARM);
  assign is_silenced     = (state_q == S_SIL);
  assign arm_fail        = fail_q;
  assign trip_zones      = tz_q;
  assign delay_remaining = (state_q == S_WAIT) ? cnt_q : '0;

endmodule

// File: tb/tb_alarm_zone_ctrl.sv
// Bench for alarm_zone_ctrl: directed scenarios plus random traffic,
// checked every cycle against a phase/elapsed-time reference model.
module tb_alarm_zone_ctrl;

  localparam int ZN = 4;
  localparam int ED = 5;
  localparam int ST = 8;
  localparam int CW = 4;

  localparam int M_DIS  = 0;
  localparam int M_ARM  = 1;
  localparam int M_WAIT = 2;
  localparam int M_ALM  = 3;
  localparam int M_SIL  = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          ENA = 1'b1;
  logic [ZN-1:0] zones = '0;
  logic [ZN-1:0] instant_mask = '0;
  logic [ZN-1:0] bypass = '0;
  logic [3:0]    keypad = '0;
  logic          keypad_valid = 1'b0;
  logic          is_armed, is_wait_delay, alarm_siren, is_silenced;
  logic          arm_fail;
  logic [ZN-1:0] trip_zones;
  logic [CW-1:0] delay_remaining;

  alarm_zone_ctrl #(
    .ZONES(ZN), .ENTRY_DELAY(ED), .SIREN_TIME(ST),
    .ARM_CODE(4'b0011), .DISARM_CODE(4'b1100)
  ) dut (
    .clk(clk), .reset_n(reset_n), .ENA(ENA),
    .zones(zones), .instant_mask(instant_mask), .bypass(bypass),
    .keypad(keypad), .keypad_valid(keypad_valid),
    .is_armed(is_armed), .is_wait_delay(is_wait_delay),
    .alarm_siren(alarm_siren), .is_silenced(is_silenced),
    .arm_fail(arm_fail), .trip_zones(trip_zones),
    .delay_remaining(delay_remaining)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic check(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a phase plus cycles elapsed inside that phase.
  int         mode = M_DIS;
  int         elapsed = 0;
  bit [ZN-1:0] m_tz = '0;
  bit [ZN-1:0] m_mask = '0;
  bit          m_fail = 1'b0;

  always @(posedge clk) begin
    bit [ZN-1:0] tr, in_, tz_new;
    bit dis, arm, fail_new;
    if (!reset_n) begin
      mode = M_DIS; elapsed = 0; m_tz = '0; m_mask = '0; m_fail = 1'b0;
    end else if (ENA) begin
      dis = keypad_valid && keypad == 4'b1100;
      arm = keypad_valid && keypad == 4'b0011;
      tr  = zones & ~m_mask;
      in_ = tr & instant_mask;
      tz_new = (mode == M_DIS) ? m_tz : (m_tz | tr);
      fail_new = 1'b0;
      if (mode == M_DIS) begin
        if (arm) begin
          if ((zones & ~bypass) == 0) begin
            mode = M_ARM; m_mask = bypass; tz_new = '0;
          end else fail_new = 1'b1;
        end
      end else if (dis) begin
        mode = M_DIS;
      end else if (mode == M_ARM) begin
        if (in_ != 0) begin mode = M_ALM; elapsed = 0; end
        else if (tr != 0) begin mode = M_WAIT; elapsed = 0; end
      end else if (mode == M_WAIT) begin
        if (in_ != 0 || elapsed == ED - 1) begin
          mode = M_ALM; elapsed = 0;
        end else elapsed++;
      end else if (mode == M_ALM) begin
        if (elapsed == ST - 1) mode = M_SIL;
        else elapsed++;
      end else begin
        if ((tr & ~m_tz) != 0) begin mode = M_ALM; elapsed = 0; end
      end
      m_tz = tz_new;
      m_fail = fail_new;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("is_armed", is_armed, mode == M_ARM);
      check("is_wait_delay", is_wait_delay, mode == M_WAIT);
      check("alarm_siren", alarm_siren, mode == M_ALM);
      check("is_silenced", is_silenced, mode == M_SIL);
      check("arm_fail", arm_fail, m_fail);
      check("trip_zones", trip_zones, m_tz);
      check("delay_remaining", delay_remaining,
            (mode == M_WAIT) ? (ED - 1 - elapsed) : 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic code(logic [3:0] c);
    keypad = c; keypad_valid = 1'b1;
    step();
    keypad_valid = 1'b0;
  endtask

  task automatic all_zero(string nm);
    check({nm, "_armed"}, is_armed, 0);
    check({nm, "_wait"}, is_wait_delay, 0);
    check({nm, "_siren"}, alarm_siren, 0);
    check({nm, "_sil"}, is_silenced, 0);
    check({nm, "_fail"}, arm_fail, 0);
    check({nm, "_dr"}, delay_remaining, 0);
  endtask

  initial begin
    reset_n = 1'b0;
    step();
    all_zero("reset");
    check("reset_tz", trip_zones, 0);
    chk_en = 1'b1;
    reset_n = 1'b1;

    code(4'b0011);
    check("arm_ok", is_armed, 1);
    check("arm_tz", trip_zones, 0);

    zones = 4'b0001;
    step();
    zones = 4'b0000;
    check("ew_enter", is_wait_delay, 1);
    check("ew_dr4", delay_remaining, 4);
    for (int i = 3; i >= 0; i--) begin
      step();
      check("ew_hold", is_wait_delay, 1);
      check("ew_dr", delay_remaining, i);
    end
    step();
    check("alm_start", alarm_siren, 1);
    for (int i = 0; i < ST - 1; i++) begin
      step();
      check("alm_hold", alarm_siren, 1);
    end
    step();
    check("sil", is_silenced, 1);
    check("sil_tz", trip_zones, 4'b0001);

    zones = 4'b0001;
    step();
    check("sil_latched", is_silenced, 1);
    zones = 4'b0100;
    step();
    zones = 4'b0000;
    check("retrig", alarm_siren, 1);
    check("retrig_tz", trip_zones, 4'b0101);
    code(4'b1100);
    all_zero("disarm");
    check("disarm_tz", trip_zones, 4'b0101);

    instant_mask = 4'b0010;
    code(4'b0011);
    zones = 4'b0010;
    step();
    zones = 4'b0000;
    check("inst_alarm", alarm_siren, 1);
    check("inst_nowait", is_wait_delay, 0);
    code(4'b1100);
    instant_mask = 4'b0000;

    bypass = 4'b1000;
    zones = 4'b1000;
    code(4'b0011);
    check("byp_arm", is_armed, 1);
    for (int i = 0; i < 4; i++) begin
      zones = (i % 2 == 0) ? 4'b0000 : 4'b1000;
      step();
      check("byp_hold", is_armed, 1);
    end
    code(4'b1100);
    bypass = 4'b0000;
    zones = 4'b1000;
    code(4'b0011);
    check("fail_pulse", arm_fail, 1);
    check("fail_dis", is_armed, 0);
    step();
    check("fail_clr", arm_fail, 0);
    zones = 4'b0000;

    code(4'b0011);
    zones = 4'b0001;
    step();
    zones = 4'b0000;
    repeat (4) step();
    check("race_dr0", delay_remaining, 0);
    code(4'b1100);
    check("race_dis_siren", alarm_siren, 0);
    check("race_dis_wait", is_wait_delay, 0);

    code(4'b0011);
    zones = 4'b0001;
    step();
    zones = 4'b0000;
    step();
    check("ena_dr3", delay_remaining, 3);
    ENA = 1'b0;
    repeat (3) step();
    check("ena_frz_dr", delay_remaining, 3);
    check("ena_frz_w", is_wait_delay, 1);
    ENA = 1'b1;
    repeat (3) step();
    check("ena_dr0", delay_remaining, 0);
    step();
    check("ena_alarm", alarm_siren, 1);
    step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    all_zero("rst_alm");
    check("rst_alm_tz", trip_zones, 0);

    for (int c = 0; c < 3000; c++) begin
      int r;
      reset_n = ($urandom_range(0, 299) != 0);
      ENA = ($urandom_range(0, 9) != 0);
      keypad_valid = ($urandom_range(0, 5) == 0);
      r = $urandom_range(0, 3);
      keypad = (r == 0) ? 4'b0011 : (r == 1) ? 4'b1100 : 4'($urandom);
      zones = 4'($urandom & $urandom & $urandom);
      instant_mask = 4'($urandom & $urandom);
      bypass = 4'($urandom & $urandom);
      step();
    end
    keypad_valid = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
